// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD sequencer.
//  - lcd_state_e : sequencer phases
//  - LCD_*_BIT   : bit positions inside the 32-bit io_lcd word
//  - INIT_ROM    : power-up command bytes (all sent with RS=0)
//  - CMD_CLEAR / CMD_HOME : commands that need the long execution wait
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        IDLE
    } lcd_state_e;

    localparam int unsigned LCD_ON_BIT = 31;
    localparam int unsigned LCD_EN_BIT = 10;
    localparam int unsigned LCD_RS_BIT = 9;
    localparam int unsigned LCD_RW_BIT = 8;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam logic [7:0] INIT_ROM [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // A zero-length phase still occupies one cycle.
    function automatic int unsigned phase_len(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one sequencer phase.
//  clk_i, rst_ni : clock, async active-low reset (counter clears to 0)
//  load_i        : reload the counter with load_val_i this edge
//  load_val_i    : phase length minus one
//  done_c        : counter is at zero (decode of the count register)
module lcd_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_c
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at zero so an idle timer never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign done_c = (r_cnt == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780 bus sequencer: power-up init, then one byte per valid/ready handshake.
//  clk_i, rst_ni : clock, async active-low reset
//  req_valid_i   : byte request valid (requester holds it until accepted)
//  req_ready_o   : sequencer idle and able to take a byte
//  req_rs_i      : 0 = command, 1 = character data
//  req_data_i    : byte to write
//  init_done_o   : init sequence finished (sticky until reset)
//  lcd_o         : {ON, 20'b0, EN, RS, RW, DATA}
// Outputs are registered from the current state, so every pin change shows
// up one cycle after the corresponding state transition.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    output logic        init_done_o,
    output logic [31:0] lcd_o
);

    localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)),
                                         max2(T_EXEC, T_CLR));
    localparam int unsigned CNT_W = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

    localparam int unsigned L_PWRUP = phase_len(T_PWRUP);
    localparam bit          PWR_MULTI = (L_PWRUP > 1);

    // Power-up spends its first cycle arming the timer, hence the extra minus one.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWR_MULTI ? (L_PWRUP - 2) : 0);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(phase_len(T_SETUP) - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(phase_len(T_EN) - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(phase_len(T_HOLD) - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(phase_len(T_EXEC) - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(phase_len(T_CLR) - 1);

    lcd_state_e       r_state;
    logic             r_armed;
    logic             r_init;
    logic [1:0]       r_idx;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_init_done;
    logic [31:0]      r_lcd;

    logic             w_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_accept;
    logic             w_pwr_arm;
    logic             w_pwr_end;
    logic             w_slow;
    logic             w_more_init;
    logic [31:0]      w_lcd_nxt;

    lcd_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .done_c     (w_done)
    );

    // Phase-end conditions shared by the timer reload and the state register.
    always_comb begin
        w_accept    = (r_state == IDLE) && r_ready && req_valid_i;
        w_pwr_arm   = (r_state == PWRUP) && !r_armed && PWR_MULTI;
        w_pwr_end   = (r_state == PWRUP) && !w_pwr_arm && (w_done || !r_armed);
        w_slow      = !r_rs && ((r_data == CMD_CLEAR) || (r_data == CMD_HOME));
        w_more_init = r_init && (r_idx != 2'd3);
    end

    // Reload the timer with the length of the phase being entered.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            PWRUP: begin
                if (w_pwr_arm) begin
                    w_load     = 1'b1;
                    w_load_val = LD_PWRUP;
                end else if (w_pwr_end) begin
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end
            end
            SETUP: begin
                w_load     = w_done;
                w_load_val = LD_EN;
            end
            PULSE: begin
                w_load     = w_done;
                w_load_val = LD_HOLD;
            end
            HOLD: begin
                w_load     = w_done;
                w_load_val = w_slow ? LD_CLR : LD_EXEC;
            end
            WAIT: begin
                w_load     = w_done && w_more_init;
                w_load_val = LD_SETUP;
            end
            IDLE: begin
                w_load     = w_accept;
                w_load_val = LD_SETUP;
            end
            default: ;
        endcase
    end

    // Pin image built from latched RS/DATA only; request inputs never reach it.
    always_comb begin
        w_lcd_nxt             = '0;
        w_lcd_nxt[LCD_ON_BIT] = 1'b1;
        w_lcd_nxt[LCD_EN_BIT] = (r_state == PULSE);
        w_lcd_nxt[LCD_RS_BIT] = r_rs;
        w_lcd_nxt[LCD_RW_BIT] = 1'b0;
        w_lcd_nxt[7:0]        = r_data;
    end

    // Sequencer state, byte latch and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= PWRUP;
            r_armed     <= 1'b0;
            r_init      <= 1'b1;
            r_idx       <= 2'd0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_lcd       <= 32'h0;
        end else begin
            r_lcd       <= w_lcd_nxt;
            r_ready     <= (r_state == IDLE) && !w_accept;
            r_init_done <= r_init_done || (r_state == IDLE);
            case (r_state)
                PWRUP: begin
                    if (w_pwr_arm) begin
                        r_armed <= 1'b1;
                    end else if (w_pwr_end) begin
                        r_rs    <= 1'b0;
                        r_data  <= INIT_ROM[0];
                        r_idx   <= 2'd0;
                        r_state <= SETUP;
                    end
                end
                SETUP: if (w_done) r_state <= PULSE;
                PULSE: if (w_done) r_state <= HOLD;
                HOLD:  if (w_done) r_state <= WAIT;
                WAIT: begin
                    if (w_done) begin
                        if (w_more_init) begin
                            r_idx   <= r_idx + 2'd1;
                            r_data  <= INIT_ROM[r_idx + 2'd1];
                            r_state <= SETUP;
                        end else begin
                            r_init  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_rs    <= req_rs_i;
                        r_data  <= req_data_i;
                        r_state <= SETUP;
                    end
                end
                default: r_state <= PWRUP;
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign init_done_o = r_init_done;
    assign lcd_o       = r_lcd;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl with short timing parameters.
module tb_lcd_seq_ctrl;

    localparam int unsigned T_PWRUP = 20;
    localparam int unsigned T_SETUP = 1;
    localparam int unsigned T_EN    = 2;
    localparam int unsigned T_HOLD  = 1;
    localparam int unsigned T_EXEC  = 5;
    localparam int unsigned T_CLR   = 10;

    logic        clk_i       = 1'b0;
    logic        rst_ni      = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_rs_i    = 1'b0;
    logic [7:0]  req_data_i  = 8'h00;
    logic        req_ready_o;
    logic        init_done_o;
    logic [31:0] lcd_o;

    lcd_seq_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLR   (T_CLR)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_rs_i    (req_rs_i),
        .req_data_i  (req_data_i),
        .init_done_o (init_done_o),
        .lcd_o       (lcd_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance one clock and sample just after the falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    // EN pulse log plus bus-stability check around each pulse.
    int          rise_cyc [$];
    int          fall_cyc [$];
    logic [31:0] rise_word [$];
    logic        prev_en   = 1'b0;
    logic [8:0]  prev_bus  = 9'h0;
    int          hold_left = 0;
    bit          prev_ok   = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            rise_cyc.delete();
            fall_cyc.delete();
            rise_word.delete();
            prev_en   = 1'b0;
            prev_ok   = 1'b0;
            hold_left = 0;
        end else begin
            if (prev_ok && (lcd_o[10] || prev_en || hold_left > 0))
                check("bus_stable", 32'({lcd_o[9], lcd_o[7:0]}), 32'(prev_bus));
            if (hold_left > 0) hold_left--;
            if (lcd_o[10] && !prev_en) begin
                rise_cyc.push_back(cyc);
                rise_word.push_back(lcd_o);
            end
            if (!lcd_o[10] && prev_en) begin
                fall_cyc.push_back(cyc);
                hold_left = int'(T_HOLD) - 1;
            end
            prev_en  = lcd_o[10];
            prev_bus = {lcd_o[9], lcd_o[7:0]};
            prev_ok  = 1'b1;
        end
    end

    // Present a byte, wait for acceptance and for ready to come back.
    task automatic send(input logic rs, input logic [7:0] d, output int acc_c, output int rdy_c);
        int t;
        req_rs_i    = rs;
        req_data_i  = d;
        req_valid_i = 1'b1;
        t = 0;
        while (!req_ready_o && t < 100) begin
            tick();
            t++;
        end
        check("send_ready_timeout", 32'(t < 100), 32'd1);
        acc_c = cyc + 1;
        tick();
        req_valid_i = 1'b0;
        check("ready_low_after_accept", 32'(req_ready_o), 32'd0);
        t = 0;
        while (!req_ready_o && t < 100) begin
            tick();
            t++;
        end
        check("ready_return_timeout", 32'(t < 100), 32'd1);
        rdy_c = cyc;
    endtask

    logic [31:0] init_words [4] = '{32'h8000_0438, 32'h8000_040C, 32'h8000_0401, 32'h8000_0406};
    int          init_gaps  [3] = '{7, 7, 12};
    logic [7:0]  b2b_data   [3] = '{8'hA1, 8'hB2, 8'hC3};
    logic        b2b_rs     [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] b2b_words  [3] = '{32'h8000_06A1, 32'h8000_04B2, 32'h8000_06C3};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rel;
        int acc;
        int rdy;
        int t;
        int n0;
        int done_c;

        // 1: reset, init sequence
        #12;
        check("rst_lcd", lcd_o, 32'h0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        rel = cyc;
        tick();
        check("on_after_release", lcd_o, 32'h8000_0000);
        check("ready_in_pwrup", 32'(req_ready_o), 32'd0);

        t = 0;
        while (!init_done_o && t < 300) begin
            check("ready_tracks_done", 32'(req_ready_o), 32'(init_done_o));
            tick();
            t++;
        end
        check("init_timeout", 32'(t < 300), 32'd1);
        check("ready_with_done", 32'(req_ready_o), 32'd1);
        check("init_pulse_count", 32'(rise_cyc.size()), 32'd4);
        if (rise_cyc.size() == 4 && fall_cyc.size() == 4) begin
            check("first_rise_after_release", 32'(rise_cyc[0] - rel), 32'(T_PWRUP + T_SETUP + 1));
            for (int k = 0; k < 4; k++) begin
                check("init_word", rise_word[k], init_words[k]);
                check("init_en_width", 32'(fall_cyc[k] - rise_cyc[k]), 32'(T_EN));
            end
            for (int k = 0; k < 3; k++)
                check("init_gap", 32'(rise_cyc[k+1] - fall_cyc[k]), 32'(init_gaps[k]));
            check("last_fall_to_ready", 32'(cyc - fall_cyc[3]), 32'(T_HOLD + T_EXEC));
        end

        // 2: character byte timing
        send(1'b1, 8'h41, acc, rdy);
        check("char_ready_latency", 32'(rdy - acc), 32'd10);
        check("char_en_rise", 32'(rise_cyc[$] - acc), 32'd2);
        check("char_en_width", 32'(fall_cyc[$] - rise_cyc[$]), 32'd2);
        check("char_pulse_word", rise_word[$], 32'h8000_0641);

        // 3: clear command waits long, same byte as data waits short
        send(1'b0, 8'h01, acc, rdy);
        check("clr_ready_latency", 32'(rdy - acc), 32'd15);
        check("clr_wait", 32'(rdy - fall_cyc[$]), 32'(T_HOLD + T_CLR));
        check("clr_word", rise_word[$], 32'h8000_0401);
        send(1'b1, 8'h01, acc, rdy);
        check("data01_ready_latency", 32'(rdy - acc), 32'd10);
        check("data01_wait", 32'(rdy - fall_cyc[$]), 32'(T_HOLD + T_EXEC));
        check("data01_word", rise_word[$], 32'h8000_0601);

        // 4: valid held across three back-to-back bytes
        n0 = rise_cyc.size();
        req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_rs_i   = b2b_rs[i];
            req_data_i = b2b_data[i];
            t = 0;
            while (!req_ready_o && t < 100) begin
                tick();
                t++;
            end
            check("b2b_ready_timeout", 32'(t < 100), 32'd1);
            tick();
        end
        req_valid_i = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("b2b_count", 32'(rise_cyc.size() - n0), 32'd3);
        if (rise_cyc.size() == n0 + 3) begin
            for (int i = 0; i < 3; i++)
                check("b2b_word", rise_word[n0+i], b2b_words[i]);
            check("b2b_spacing", 32'(rise_cyc[n0+1] - rise_cyc[n0]), 32'd11);
        end

        // 5: reset during EN pulse, init repeats, held request waits for it
        req_rs_i    = 1'b1;
        req_data_i  = 8'h77;
        req_valid_i = 1'b1;
        t = 0;
        while (!req_ready_o && t < 100) begin
            tick();
            t++;
        end
        tick();
        req_valid_i = 1'b0;
        t = 0;
        while (!lcd_o[10] && t < 20) begin
            tick();
            t++;
        end
        check("en_seen_before_reset", 32'(lcd_o[10]), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_rst_lcd", lcd_o, 32'h0);
        check("async_rst_ready", 32'(req_ready_o), 32'd0);
        check("async_rst_done", 32'(init_done_o), 32'd0);
        req_rs_i    = 1'b1;
        req_data_i  = 8'h5A;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        rel = cyc;
        t = 0;
        while (!init_done_o && t < 300) begin
            check("ready_low_during_reinit", 32'(req_ready_o), 32'd0);
            tick();
            t++;
        end
        check("reinit_timeout", 32'(t < 300), 32'd1);
        done_c = cyc;
        check("reinit_pulse_count", 32'(rise_cyc.size()), 32'd4);
        if (rise_cyc.size() == 4) begin
            check("reinit_first_rise", 32'(rise_cyc[0] - rel), 32'(T_PWRUP + T_SETUP + 1));
            for (int k = 0; k < 4; k++)
                check("reinit_word", rise_word[k], init_words[k]);
        end
        tick();
        req_valid_i = 1'b0;
        t = 0;
        while (rise_cyc.size() < 5 && t < 30) begin
            tick();
            t++;
        end
        check("held_req_count", 32'(rise_cyc.size()), 32'd5);
        if (rise_cyc.size() == 5) begin
            check("held_req_word", rise_word[4], 32'h8000_065A);
            check("held_req_rise", 32'(rise_cyc[4] - done_c), 32'd3);
        end
        for (int i = 0; i < 20; i++) tick();
        check("no_extra_transfer", 32'(rise_cyc.size()), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
